// File: rtl/tile_cfg.sv
// rtl/tile_cfg.sv - per-tile config store fed by a soft scan chain and a hard load chain
// Optional: TILE_CFG_CLEAR_ON_SET_EN clears the committing chain on a set instead of shifting it.
module tile_cfg #(
  parameter int COMB_W   = 5,
  parameter int MEM_W    = 7,
  parameter int SOFT_LEN = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_in_soft,
  input  logic              set_soft,
  input  logic              shift_in_hard,
  input  logic              set_hard,
  output logic              shift_out,
  output logic [COMB_W-1:0] comb_config,
  output logic [MEM_W-1:0]  mem_config
);

  localparam int HARD_W = COMB_W + MEM_W;

  typedef enum logic {
    TGT_COMB = 1'b0,
    TGT_MEM  = 1'b1
  } tgt_t;

  tgt_t                r_tgt;
  tgt_t                w_tgt_nxt;
  logic [SOFT_LEN-1:0] r_sreg;
  logic [SOFT_LEN-1:0] w_sreg_nxt;
  logic [HARD_W-1:0]   r_hreg;
  logic [HARD_W-1:0]   w_hreg_nxt;
  logic [COMB_W-1:0]   r_comb;
  logic [MEM_W-1:0]    r_mem;
  logic                w_soft_commit;
  logic                w_comb_we;
  logic                w_mem_we;
  logic [COMB_W-1:0]   w_comb_d;
  logic [MEM_W-1:0]    w_mem_d;

  // A hard commit always takes priority over a soft one in the same cycle.
  assign w_soft_commit = set_soft & ~set_hard;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tgt <= TGT_COMB;
    end else begin
      r_tgt <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_tgt_nxt = r_tgt;
    if (set_hard) begin
      w_tgt_nxt = TGT_COMB;
    end else if (w_soft_commit) begin
      w_tgt_nxt = (r_tgt == TGT_COMB) ? TGT_MEM : TGT_COMB;
    end
  end

  always_comb begin
    w_comb_we = 1'b0;
    w_mem_we  = 1'b0;
    w_comb_d  = r_sreg[COMB_W-1:0];
    w_mem_d   = r_sreg[MEM_W-1:0];
    if (set_hard) begin
      w_comb_we = 1'b1;
      w_mem_we  = 1'b1;
      w_comb_d  = r_hreg[COMB_W-1:0];
      w_mem_d   = r_hreg[HARD_W-1:COMB_W];
    end else if (w_soft_commit) begin
      if (r_tgt == TGT_COMB) begin
        w_comb_we = 1'b1;
      end else begin
        w_mem_we = 1'b1;
      end
    end
  end

  // Chains shift every cycle; commits sample the pre-shift contents.
  always_comb begin
    w_sreg_nxt = {r_sreg[SOFT_LEN-2:0], shift_in_soft};
    w_hreg_nxt = {r_hreg[HARD_W-2:0], shift_in_hard};
`ifdef TILE_CFG_CLEAR_ON_SET_EN
    if (w_soft_commit) begin
      w_sreg_nxt = {{(SOFT_LEN-1){1'b0}}, shift_in_soft};
    end
    if (set_hard) begin
      w_hreg_nxt = {{(HARD_W-1){1'b0}}, shift_in_hard};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
      r_hreg <= '0;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_hreg <= w_hreg_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_comb <= '0;
      r_mem  <= '0;
    end else begin
      if (w_comb_we) begin
        r_comb <= w_comb_d;
      end
      if (w_mem_we) begin
        r_mem <= w_mem_d;
      end
    end
  end

  assign shift_out   = r_sreg[SOFT_LEN-1];
  assign comb_config = r_comb;
  assign mem_config  = r_mem;

endmodule

// File: tb/tb_tile_cfg.sv
// tb/tb_tile_cfg.sv - directed self-checking bench for tile_cfg
// Covers TILE_CFG_CLEAR_ON_SET_EN behaviour when that macro is defined.
module tb_tile_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shift_in_soft = 1'b0;
  logic       set_soft = 1'b0;
  logic       shift_in_hard = 1'b0;
  logic       set_hard = 1'b0;
  logic       shift_out;
  logic [4:0] comb_config;
  logic [6:0] mem_config;

  int errors = 0;
  int checks = 0;

  tile_cfg #(.COMB_W(5), .MEM_W(7), .SOFT_LEN(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .shift_in_soft (shift_in_soft),
    .set_soft      (set_soft),
    .shift_in_hard (shift_in_hard),
    .set_hard      (set_hard),
    .shift_out     (shift_out),
    .comb_config   (comb_config),
    .mem_config    (mem_config)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_soft_bits(input logic [6:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      shift_in_soft = bits[i];
      tick();
    end
    shift_in_soft = 1'b0;
  endtask

  task automatic shift_hard_bits(input logic [11:0] bits);
    for (int i = 11; i >= 0; i--) begin
      shift_in_hard = bits[i];
      tick();
    end
    shift_in_hard = 1'b0;
  endtask

  task automatic pulse_soft();
    set_soft = 1'b1;
    tick();
    set_soft = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (shift_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge_shift_out: got %b required 0", shift_out);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (comb_config !== 5'h00) begin
      errors++;
      $display("FAIL reset_comb: got %h required 00", comb_config);
    end
    checks++;
    if (mem_config !== 7'h00) begin
      errors++;
      $display("FAIL reset_mem: got %h required 00", mem_config);
    end
    checks++;
    if (shift_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_shift_out: got %b required 0", shift_out);
    end
  endtask

  task automatic test_pass_through();
    logic [13:0] pat;
    logic        exp;
    pat = 14'b10101011010000;
    for (int k = 0; k < 20; k++) begin
      shift_in_soft = (k < 14) ? pat[13 - k] : 1'b0;
      tick();
      exp = (k >= 6) ? pat[13 - (k - 6)] : 1'b0;
      checks++;
      if (shift_out !== exp) begin
        errors++;
        $display("FAIL pass_through_edge%0d: got %b required %b", k, shift_out, exp);
      end
    end
    shift_in_soft = 1'b0;
    checks++;
    if (comb_config !== 5'h00 || mem_config !== 7'h00) begin
      errors++;
      $display("FAIL pass_through_configs_hold: got comb=%h mem=%h required 00/00", comb_config, mem_config);
    end
  endtask

  task automatic test_soft_load();
    shift_soft_bits(7'b0010110, 5);
    pulse_soft();
    checks++;
    if (comb_config !== 5'h16) begin
      errors++;
      $display("FAIL soft_comb: got %h required 16", comb_config);
    end
    checks++;
    if (mem_config !== 7'h00) begin
      errors++;
      $display("FAIL soft_mem_untouched: got %h required 00", mem_config);
    end
    shift_soft_bits(7'b1100101, 7);
    pulse_soft();
    checks++;
    if (mem_config !== 7'h65) begin
      errors++;
      $display("FAIL soft_mem: got %h required 65", mem_config);
    end
    checks++;
    if (comb_config !== 5'h16) begin
      errors++;
      $display("FAIL soft_comb_held: got %h required 16", comb_config);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_mem;
`ifdef TILE_CFG_CLEAR_ON_SET_EN
    exp_mem = 7'h01;
`else
    exp_mem = 7'h67;
`endif
    shift_soft_bits(7'b1110011, 7);
    set_soft = 1'b1;
    shift_in_soft = 1'b1;
    tick();
    checks++;
    if (comb_config !== 5'h13 || mem_config !== 7'h65) begin
      errors++;
      $display("FAIL held_set_first: got comb=%h mem=%h required 13/65", comb_config, mem_config);
    end
    shift_in_soft = 1'b0;
    tick();
    set_soft = 1'b0;
    checks++;
    if (mem_config !== exp_mem || comb_config !== 5'h13) begin
      errors++;
      $display("FAIL held_set_second: got comb=%h mem=%h required 13/%h", comb_config, mem_config, exp_mem);
    end
  endtask

  task automatic test_hard_load();
    shift_soft_bits(7'b0000001, 5);
    pulse_soft();
    shift_hard_bits({7'h2A, 5'h09});
    checks++;
    if (comb_config !== 5'h01) begin
      errors++;
      $display("FAIL hard_shift_no_effect: got comb=%h required 01", comb_config);
    end
    set_hard = 1'b1;
    tick();
    set_hard = 1'b0;
    checks++;
    if (comb_config !== 5'h09 || mem_config !== 7'h2A) begin
      errors++;
      $display("FAIL hard_commit: got comb=%h mem=%h required 09/2a", comb_config, mem_config);
    end
    shift_soft_bits(7'b0000111, 5);
    pulse_soft();
    checks++;
    if (comb_config !== 5'h07 || mem_config !== 7'h2A) begin
      errors++;
      $display("FAIL hard_pointer_reset: got comb=%h mem=%h required 07/2a", comb_config, mem_config);
    end
  endtask

  task automatic test_conflict();
    logic [11:0] hbits;
    hbits = {7'h55, 5'h0A};
    for (int i = 11; i >= 0; i--) begin
      shift_in_soft = 1'b1;
      shift_in_hard = hbits[i];
      tick();
    end
    shift_in_hard = 1'b0;
    set_soft = 1'b1;
    set_hard = 1'b1;
    tick();
    set_soft = 1'b0;
    set_hard = 1'b0;
    shift_in_soft = 1'b0;
    checks++;
    if (comb_config !== 5'h0A || mem_config !== 7'h55) begin
      errors++;
      $display("FAIL conflict_hard_wins: got comb=%h mem=%h required 0a/55", comb_config, mem_config);
    end
    shift_soft_bits(7'b0000011, 5);
    pulse_soft();
    checks++;
    if (comb_config !== 5'h03 || mem_config !== 7'h55) begin
      errors++;
      $display("FAIL conflict_pointer_comb: got comb=%h mem=%h required 03/55", comb_config, mem_config);
    end
  endtask

`ifdef TILE_CFG_CLEAR_ON_SET_EN
  task automatic test_clear_on_set();
    shift_soft_bits(7'b1111111, 7);
    set_soft = 1'b1;
    shift_in_soft = 1'b1;
    tick();
    set_soft = 1'b0;
    shift_in_soft = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (shift_out !== 1'b0) begin
        errors++;
        $display("FAIL clear_on_set_zero%0d: got %b required 0", k, shift_out);
      end
      tick();
    end
    checks++;
    if (shift_out !== 1'b1) begin
      errors++;
      $display("FAIL clear_on_set_new_bit: got %b required 1", shift_out);
    end
  endtask
`endif

  task automatic test_reset_mid_load();
    shift_soft_bits(7'b1111111, 7);
    shift_soft_bits(7'b0000101, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (comb_config !== 5'h00 || mem_config !== 7'h00) begin
      errors++;
      $display("FAIL mid_reset_configs: got comb=%h mem=%h required 00/00", comb_config, mem_config);
    end
    checks++;
    if (shift_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_shift_out: got %b required 0", shift_out);
    end
    shift_soft_bits(7'b0001101, 5);
    pulse_soft();
    checks++;
    if (comb_config !== 5'h0D || mem_config !== 7'h00) begin
      errors++;
      $display("FAIL mid_reset_reload: got comb=%h mem=%h required 0d/00", comb_config, mem_config);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_soft_load();
    test_back_to_back();
    test_hard_load();
    test_conflict();
`ifdef TILE_CFG_CLEAR_ON_SET_EN
    test_clear_on_set();
`endif
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
